multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 43 ++++
 rtl/multicycle_controller_fetch_watchdog.sv | 37 +++
 rtl/multicycle_controller.sv | 165 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller and its neighbours
// (immediate generator, ALU control): opcode constants, state encoding,
// alu_op codes and trap_cause codes.
package multicycle_controller_pkg;

  // Controller states; the encoding is also exported on state_dbg.
  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd5
  } state_e;

  // Supported major opcodes
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcReg    = 7'b0110011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  // Branch funct3 values
  localparam logic [2:0] F3Beq = 3'b000;
  localparam logic [2:0] F3Bne = 3'b001;

  // alu_op codes
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  // trap_cause codes
  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseOpcode  = 2'b01;
  localparam logic [1:0] CauseFunct3  = 2'b10;
  localparam logic [1:0] CauseTimeout = 2'b11;

  // Width of the fetch watchdog counter; covers timeouts up to 255.
  localparam int unsigned WdogW = 8;

  function automatic logic opcode_legal(input logic [6:0] opc);
    return (opc == OpcImm) || (opc == OpcReg) || (opc == OpcBranch);
  endfunction

endpackage

// File: rtl/multicycle_controller_fetch_watchdog.sv
// Fetch watchdog: counts FETCH cycles that end without an instruction
// memory ack and flags the cycle in which the count reaches the timeout.
//   clk     in  clock
//   rst_n   in  synchronous active-low reset
//   clear   in  hold counter at zero (asserted whenever not fetching)
//   tick    in  one FETCH cycle elapsed without ack
//   expired out this tick brings the count to Timeout
module fetch_watchdog
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned Timeout = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam logic [WdogW-1:0] LastCount = WdogW'(Timeout - 1);

  logic [WdogW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= count_q + WdogW'(1);
    end
  end

  // Combinational so the controller can leave FETCH on the tick that hits the limit.
  assign expired = tick && (count_q == LastCount);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: IDLE -> FETCH -> DECODE -> EXECUTE
// [-> WRITEBACK] -> FETCH, with an absorbing TRAP state for illegal
// opcodes, illegal branch funct3 and fetch timeouts.
//   clk, rst_n      clock, synchronous active-low reset
//   imem_ack        fetch ack; instr_in valid in the same cycle
//   instr_in        instruction word
//   alu_zero        ALU zero flag, used during EXECUTE of a branch
//   imem_req        fetch request
//   ir_write        instruction register load strobe
//   opcode          registered IR[6:0]
//   alu_src_imm     ALU operand B from the immediate
//   alu_op          00 add, 01 sub, 10 funct-decoded
//   reg_write       register-file write enable
//   pc_write        PC update enable, pc_src selects PC+4 (0) or PC+imm (1)
//   trap            sticky error flag, trap_cause gives the reason
//   retire_count    retired-instruction counter (wraps)
//   state_dbg       current state encoding
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_ack,
  input  logic [31:0]      instr_in,
  input  logic             alu_zero,
  output logic             imem_req,
  output logic             ir_write,
  output logic [6:0]       opcode,
  output logic             alu_src_imm,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retire_count,
  output logic [2:0]       state_dbg
);

  state_e           state_q, state_d;
  logic [31:0]      ir_q;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retire_q;
  logic             retire;
  logic             wdog_clear, wdog_tick, wdog_expired;
  logic [2:0]       funct3;
  logic             is_branch;

  assign funct3    = ir_q[14:12];
  assign is_branch = (ir_q[6:0] == OpcBranch);

  // The datapath owns the remaining IR fields.
  logic unused_ir;
  assign unused_ir = ^{ir_q[31:15], ir_q[11:7]};

  assign wdog_clear = (state_q != StFetch);
  assign wdog_tick  = (state_q == StFetch) && !imem_ack;

  fetch_watchdog #(
    .Timeout (MEM_TIMEOUT)
  ) u_fetch_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wdog_clear),
    .tick    (wdog_tick),
    .expired (wdog_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ir_q     <= '0;
      cause_q  <= CauseNone;
      retire_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (ir_write) begin
        ir_q <= instr_in;
      end
      if (retire) begin
        retire_q <= retire_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    retire      = 1'b0;
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = AluAdd;
    reg_write   = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    trap        = 1'b0;

    case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          // Gated by rst_n so a coincident reset keeps the strobe low.
          ir_write = rst_n;
          state_d  = StDecode;
        end else if (wdog_expired) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end
      end
      StDecode: begin
        if (opcode_legal(ir_q[6:0])) begin
          state_d = StExecute;
        end else begin
          state_d = StTrap;
          cause_d = CauseOpcode;
        end
      end
      StExecute: begin
        alu_src_imm = (ir_q[6:0] == OpcImm);
        alu_op      = is_branch ? AluSub : AluFunct;
        if (is_branch) begin
          if ((funct3 == F3Beq) || (funct3 == F3Bne)) begin
            pc_write = 1'b1;
            pc_src   = (funct3 == F3Beq) ? alu_zero : !alu_zero;
            retire   = 1'b1;
            state_d  = StFetch;
          end else begin
            state_d = StTrap;
            cause_d = CauseFunct3;
          end
        end else begin
          state_d = StWriteback;
        end
      end
      StWriteback: begin
        alu_src_imm = (ir_q[6:0] == OpcImm);
        alu_op      = AluFunct;
        reg_write   = 1'b1;
        pc_write    = 1'b1;
        retire      = 1'b1;
        state_d     = StFetch;
      end
      StTrap: begin
        trap = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign opcode       = ir_q[6:0];
  assign trap_cause   = cause_q;
  assign retire_count = retire_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. A trace model builds the
// expected per-cycle outputs of each instruction from its class, fetch wait
// count and alu_zero; randomized instruction streams are compared against it.
// CNT_W is set to 4 so retire_count wrap is reached by retiring 16 instructions.
module tb_multicycle_controller;

  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_ack = 1'b0;
  logic [31:0]   instr_in = '0;
  logic          alu_zero = 1'b0;
  logic          imem_req, ir_write, alu_src_imm, reg_write, pc_write, pc_src, trap;
  logic [6:0]    opcode;
  logic [1:0]    alu_op, trap_cause;
  logic [CW-1:0] retire_count;
  logic [2:0]    state_dbg;

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_ret = '0;

  always #5 clk = ~clk;

  multicycle_controller #(
    .MEM_TIMEOUT (TMO),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_ack     (imem_ack),
    .instr_in     (instr_in),
    .alu_zero     (alu_zero),
    .imem_req     (imem_req),
    .ir_write     (ir_write),
    .opcode       (opcode),
    .alu_src_imm  (alu_src_imm),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .retire_count (retire_count),
    .state_dbg    (state_dbg)
  );

  // Expected control vector: state, req, irw, imm, op, rw, pw, ps, trap, cause
  function automatic logic [13:0] mk(input int st, input bit req, input bit irw, input bit imm,
                                     input int op, input bit rw, input bit pw, input bit ps,
                                     input bit tr, input int cause);
    return {3'(st), req, irw, imm, 2'(op), rw, pw, ps, tr, 2'(cause)};
  endfunction

  function automatic logic [13:0] observe();
    return {state_dbg, imem_req, ir_write, alu_src_imm, alu_op, reg_write, pc_write, pc_src,
            trap, trap_cause};
  endfunction

  // kind: 0 I-ALU, 1 R-ALU, 2 legal branch, 3 branch with bad funct3, 4 bad opcode
  function automatic logic [31:0] gen_instr(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      0: r[6:0] = 7'h13;
      1: r[6:0] = 7'h33;
      2: begin r[6:0] = 7'h63; r[14:13] = 2'b00; end
      3: begin r[6:0] = 7'h63; if (r[14:13] == 2'b00) r[13] = 1'b1; end
      default: begin
        while (r[6:0] == 7'h13 || r[6:0] == 7'h33 || r[6:0] == 7'h63) r[6:0] = 7'($urandom);
      end
    endcase
    return r;
  endfunction

  task automatic step(input bit a, input logic [31:0] d, input bit z);
    @(negedge clk);
    imem_ack = a;
    instr_in = d;
    alu_zero = z;
    #1;
  endtask

  // Leaves the bench in the IDLE cycle right after reset release.
  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_ret = '0;
  endtask

  // Runs one instruction from its first FETCH cycle; waits = cycles before ack.
  task automatic run_instr(input logic [31:0] ins, input int waits, input bit az,
                           output bit trapped);
    logic [14:0] q[$];
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [13:0] got;
    logic [31:0] d;
    int          nf;
    bit          acked, a, is_i, is_r, is_b, taken;
    opc   = ins[6:0];
    f3    = ins[14:12];
    acked = (waits < int'(TMO));
    nf    = acked ? waits + 1 : int'(TMO);
    is_i  = (opc == 7'h13);
    is_r  = (opc == 7'h33);
    is_b  = (opc == 7'h63);
    trapped = 1'b0;
    for (int i = 0; i < nf; i++) q.push_back({1'b0, mk(1, 1, acked && i == waits, 0, 0, 0, 0, 0, 0, 0)});
    if (!acked) begin
      q.push_back({1'b0, mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 3)});
      trapped = 1'b1;
    end else begin
      q.push_back({1'b0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
      if (!(is_i || is_r || is_b)) begin
        q.push_back({1'b0, mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 1)});
        trapped = 1'b1;
      end else if (is_b) begin
        if (f3 == 3'd0 || f3 == 3'd1) begin
          taken = (f3 == 3'd0) ? az : !az;
          q.push_back({1'b1, mk(3, 0, 0, 0, 1, 0, 1, taken, 0, 0)});
        end else begin
          q.push_back({1'b0, mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0)});
          q.push_back({1'b0, mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 2)});
          trapped = 1'b1;
        end
      end else begin
        q.push_back({1'b0, mk(3, 0, 0, is_i, 2, 0, 0, 0, 0, 0)});
        q.push_back({1'b1, mk(4, 0, 0, is_i, 2, 1, 1, 0, 0, 0)});
      end
    end
    for (int i = 0; i < q.size(); i++) begin
      if (i < nf) a = acked && (i == waits);
      else a = 1'($urandom_range(0, 1));
      d = (a && i < nf) ? ins : $urandom;
      step(a, d, az);
      got = observe();
      checks++;
      if (got !== q[i][13:0]) begin
        errors++;
        $display("FAIL ctrl_vec instr=%h cycle=%0d got=%h want=%h", ins, i, got, q[i][13:0]);
      end
      checks++;
      if (retire_count !== exp_ret) begin
        errors++;
        $display("FAIL retire_count instr=%h cycle=%0d got=%0d want=%0d", ins, i,
                 retire_count, exp_ret);
      end
      if (acked && i == nf) begin
        checks++;
        if (opcode !== opc) begin
          errors++;
          $display("FAIL opcode instr=%h got=%h want=%h", ins, opcode, opc);
        end
      end
      if (q[i][14]) exp_ret = exp_ret + CW'(1);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (observe() !== 14'd0 || retire_count !== '0 || opcode !== 7'd0) begin
      errors++;
      $display("FAIL reset_held got=%h/%0d/%h want=0/0/0", observe(), retire_count, opcode);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (observe() !== 14'd0 || retire_count !== '0) begin
      errors++;
      $display("FAIL reset_release_cycle got=%h want=0", observe());
    end
    step(0, '0, 0);
    checks++;
    if (observe() !== mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL first_fetch got=%h want=%h", observe(), mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_alu();
    bit t;
    do_reset();
    run_instr(32'h0050_0093, 2, 0, t);
    step(0, '0, 0);
    checks++;
    if (retire_count !== CW'(1) || state_dbg !== 3'd1) begin
      errors++;
      $display("FAIL addi_retire got=%0d/%0d want=1/1", retire_count, state_dbg);
    end
    do_reset();
    for (int n = 0; n < 6; n++) run_instr(gen_instr(n % 2), $urandom_range(0, 2), 1'($urandom), t);
  endtask

  task automatic test_branch();
    bit t;
    do_reset();
    run_instr(32'h0000_0463, 0, 1, t);
    run_instr(32'h0000_0463, 1, 0, t);
    run_instr(32'h0000_1463, 0, 0, t);
    run_instr(32'h0000_1463, 2, 1, t);
    step(0, '0, 0);
    checks++;
    if (retire_count !== CW'(4)) begin
      errors++;
      $display("FAIL branch_retire got=%0d want=4", retire_count);
    end
  endtask

  task automatic test_illegal_trap();
    bit t;
    do_reset();
    run_instr(32'h0050_0093, 0, 0, t);
    run_instr(32'h0000_007F, 1, 0, t);
    for (int i = 0; i < 20; i++) begin
      step(1'(i % 2), $urandom, 1'($urandom));
      checks++;
      if (observe() !== mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 1) || retire_count !== exp_ret) begin
        errors++;
        $display("FAIL trap_hold i=%0d got=%h/%0d want=%h/%0d", i, observe(), retire_count,
                 mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 1), exp_ret);
      end
    end
    @(negedge clk);
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (observe() !== 14'd0 || retire_count !== '0 || opcode !== 7'd0) begin
      errors++;
      $display("FAIL trap_reset got=%h/%0d/%h want=0/0/0", observe(), retire_count, opcode);
    end
    rst_n = 1'b1;
    do_reset();
    run_instr(32'h0000_2463, 1, 0, t);
  endtask

  task automatic test_timeout();
    bit t;
    do_reset();
    run_instr(32'h0050_0093, 10, 0, t);
    checks++;
    if (trap_cause !== 2'd3) begin
      errors++;
      $display("FAIL timeout_cause got=%0d want=3", trap_cause);
    end
    do_reset();
    run_instr(32'h0050_0093, int'(TMO) - 1, 0, t);
  endtask

  task automatic test_wrap();
    bit t;
    do_reset();
    for (int n = 0; n < 16; n++) run_instr(gen_instr(n % 2), $urandom_range(0, 2), 0, t);
    step(0, '0, 0);
    checks++;
    if (retire_count !== '0) begin
      errors++;
      $display("FAIL retire_wrap got=%0d want=0", retire_count);
    end
  endtask

  task automatic test_reset_ack();
    do_reset();
    step(0, '0, 0);
    @(negedge clk);
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    instr_in = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    checks++;
    if (observe() !== 14'd0 || opcode !== 7'd0) begin
      errors++;
      $display("FAIL reset_vs_ack got=%h/%h want=0/0", observe(), opcode);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit t;
    int k;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 9);
      if (k <= 2) k = 0;
      else if (k <= 5) k = 1;
      else if (k <= 8) k = 2;
      else k = $urandom_range(3, 4);
      run_instr(gen_instr(k), $urandom_range(0, TMO), 1'($urandom), t);
      if (t) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_illegal_trap();
    test_timeout();
    test_wrap();
    test_reset_ack();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule
